count8_sched: RTL
=================

# count8_sched

Two-requester scheduler for the shared 8-bit loadable up-counter. It grants the counter to one requester at a time (round-robin) and loads it with 8'h00. It then enables counting until the requester's programmed length is reached, pulses `done` to the owner, and releases the counter. It sits between interval-timing clients and the counter datapath, and drives that counter's `load`/`EN`/`CNT_In` so no client touches them directly.

## Interface
- `CNT_W`, 8, counter width; the only supported value is 8.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `res`  in  1  reset, synchronous, active-low.
- `req`  in  2  `req[i]` = requester i wants an interval; sampled only in IDLE.
- `len0`  in  8  interval length for requester 0, in enabled count cycles; latched at grant.
- `len1`  in  8  interval length for requester 1, latched at grant.
- `pause`  in  1  freezes counting while in RUN; ignored in other states.
- `gnt`  out  2  one-hot owner, registered; high from LOAD through DONE.
- `done`  out  2  one-cycle pulse on `done[owner]` in the DONE state.
- `busy`  out  1  state != IDLE.
- `CNT`  out  8  live counter value.

## Operation
- FSM states and transitions:
  - IDLE:
    - If `req`==00, stay in IDLE.
    - Otherwise pick a winner. A single requester wins outright. If both request, the one not granted last wins.
    - Latch the winner's `len` into `len_q`, set `gnt`, go to LOAD.
  - LOAD:
    - Counter `load`=1, `CNT_In`=8'h00.
    - If `len_q`==0, go to DONE; otherwise go to RUN.
  - RUN:
    - Counter enable: `EN` = !`pause` && (`CNT` != `len_q`).
    - Go to DONE when `EN` && `CNT`==`len_q`-1, i.e. the counter reaches `len_q` on that edge.
  - DONE:
    - `done[owner]`=1 for exactly this cycle; `gnt` is still held.
    - Update the last-granted pointer, go to IDLE. `gnt` clears on entering IDLE.
- Transactions are non-abortable. Dropping `req` after grant has no effect.
  - A requester still holding `req` in IDLE re-enters arbitration.
- Changes to `len0`/`len1` after the latch are ignored until the next grant.
- Round-robin pointer resets to favour requester 0.
- Counter never wraps under scheduler control, since `len_q` ≤ 8'hFF.

## Timing
- Reset values (first edge with `res`=0): state IDLE, `gnt`=00, `done`=00, `busy`=0, `CNT`=8'h00, pointer favours requester 0.
- Reset mid-transaction aborts it: no `done` pulse, `len_q` is discarded.
- `req` sampled at edge k in IDLE gives:
  - LOAD (`gnt` high, `busy` high) during cycle k+1.
  - RUN during cycles k+2 … k+1+len, with no pause.
  - DONE pulse in cycle k+2+len; IDLE at k+3+len.
- Each paused RUN cycle extends the interval by one cycle; `CNT` holds.
- `len`=0: LOAD at k+1, DONE at k+2; RUN is skipped.
- Back-to-back grants have a minimum gap of one IDLE cycle between DONE and the next LOAD.
- `CNT` equals `len_q` during DONE. It stays at that value through IDLE until the next LOAD.

## Structure
- Shared package `count8_sched_pkg` holds:
  - the state encoding: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11;
  - `CNT_W`;
  - the requester-index constants.
- One sub-module, `count8_core`, is the 8-bit up-counter. It has the same ports as the team's counters: `clk`, `res`, `EN`, `load`, `CNT_In`, `CNT`.
  - Reset is synchronous active-low to 8'h00.
  - `load` has priority over `EN`.
  - FF wraps to 00.
- Arbitration, FSM, `len_q` and the pointer live in the top module.

## Test plan
- Reset: hold `res`=0 for 2 edges with `req`=11 → `gnt`=00, `done`=00, `busy`=0, `CNT`=8'h00 throughout.
- Single request: `req`=01 at edge k, `len0`=8'h05 → `gnt`=01 for k+1..k+7; `CNT` steps 0,1,2,3,4,5; `done`=01 only in cycle k+7; `busy` low at k+8.
- Contention: `req`=11 held, `len0`=3, `len1`=4 → grants alternate 01,10,01. `done[0]` at k+5, `done[1]` at k+12, then `done[0]` at k+18.
- Pause: `len0`=4, `pause` high for 3 cycles while `CNT`=2 → `CNT` holds at 2, `done` is delayed by exactly 3 cycles to k+9.
- Zero length: `len1`=0, `req`=10 → LOAD at k+1, `done`=10 at k+2, `CNT` stays 00.
- Reset mid-RUN: `res`=0 when `CNT`=2 → next edge gives all outputs at reset values with no `done` pulse. After release with `req`=11, requester 0 is granted first.

Source files
------------

// File: rtl/count8_sched_pkg.sv
// Shared constants for the two-requester counter scheduler: counter width,
// FSM state encoding and requester indices.
package count8_sched_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/count8_core.sv
// 8-bit loadable up-counter. A load takes priority over counting, and the
// counter wraps from FF to 00.
module count8_core
    import count8_sched_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [CNT_W-1:0] CNT_In,
    output logic [CNT_W-1:0] CNT
);

    // Counter register: synchronous active-low reset, then load, then count.
    always_ff @(posedge clk) begin
        if (!res) begin
            CNT <= '0;
        end else if (load) begin
            CNT <= CNT_In;
        end else if (EN) begin
            CNT <= CNT + CNT_W'(1);
        end
    end

endmodule

// File: rtl/count8_sched.sv
// Round-robin scheduler that owns the shared counter. It grants one requester
// at a time, clears the counter, counts up to that requester's latched length
// and then pulses done to the owner.
//
// Handshake: a requester raises req[i] and keeps it up until it sees gnt[i];
// req is only looked at while idle, so dropping it after the grant has no
// effect. The transaction always runs to completion (only reset aborts it)
// and ends with a single-cycle done[i] while gnt[i] is still high; gnt drops
// on the following cycle.
module count8_sched
    import count8_sched_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic             pause,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] CNT,
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] len_q;
    logic             owner;
    logic             last;
    logic             winner;
    logic             cnt_load;
    logic             cnt_en;

    // Arbitration: a lone requester wins; on contention the one not served last.
    always_comb begin
        winner = ~last;
        if (req == 2'b01) begin
            winner = REQ0;
        end else if (req == 2'b10) begin
            winner = REQ1;
        end
    end

    // Counter controls: clear in LOAD, count in RUN until the length is reached.
    always_comb begin
        cnt_load = (state == ST_LOAD);
        cnt_en   = (state == ST_RUN) && !pause && (CNT != len_q);
    end

    count8_core u_core (
        .clk    (clk),
        .res    (res),
        .EN     (cnt_en),
        .load   (cnt_load),
        .CNT_In (LOAD_VALUE),
        .CNT    (CNT)
    );

    // Scheduler FSM with grant, latched length, owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!res) begin
            state <= ST_IDLE;
            gnt   <= 2'b00;
            len_q <= '0;
            owner <= REQ0;
            last  <= REQ1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        len_q <= winner ? len1 : len0;
                        owner <= winner;
                        gnt   <= onehot_of(winner);
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= (len_q == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_en && (CNT == len_q - CNT_W'(1))) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last  <= owner;
                    gnt   <= 2'b00;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign done      = (state == ST_DONE) ? gnt : 2'b00;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule
